// File: rtl/save_mem_arbiter.sv
// rtl/save_mem_arbiter.sv - round-robin savestate memory arbiter (gb core vs host)
module save_mem_arbiter #(
  parameter int ADDR_W      = 26,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic              hclk,
  input  logic              reset,
  input  logic              core_ena,
  input  logic              core_rnw,
  input  logic [ADDR_W-1:0] core_adr,
  input  logic [63:0]       core_din,
  output logic [63:0]       core_dout,
  output logic              core_done,
  input  logic              host_req,
  input  logic              host_rnw,
  input  logic [ADDR_W-1:0] host_adr,
  input  logic [63:0]       host_din,
  input  logic [7:0]        host_be,
  output logic [63:0]       host_dout,
  output logic              host_ack,
  output logic              mem_req,
  output logic              mem_rnw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_din,
  output logic [7:0]        mem_be,
  input  logic              mem_ready,
  input  logic [63:0]       mem_dout,
  output logic              owner,
  output logic              busy,
  output logic              timeout_err,
  output logic              overrun_err
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                core_pend_q, core_pend_d;
  logic                core_rnw_q, core_rnw_d;
  logic [ADDR_W-1:0]   core_adr_q, core_adr_d;
  logic [63:0]         core_din_q, core_din_d;
  logic                guard_q, guard_d;
  logic                owner_q, owner_d;
  logic                mem_rnw_q, mem_rnw_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [63:0]         mem_din_q, mem_din_d;
  logic [7:0]          mem_be_q, mem_be_d;
  logic [63:0]         core_dout_q, core_dout_d;
  logic [63:0]         host_dout_q, host_dout_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic                overrun_q, overrun_d;

  logic host_cand, grant_core, grant_host, core_free, cnt_last;

  // On a tie the requester that did not hold the last grant wins.
  always_comb begin
    host_cand  = host_req && !guard_q;
    grant_core = core_pend_q && (!host_cand || owner_q);
    grant_host = host_cand && (!core_pend_q || !owner_q);
    core_free  = !core_pend_q || (state_q == S_RESP && !owner_q);
    cnt_last   = (cnt_q == CNT_LAST);
  end

  always_ff @(posedge hclk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_core || grant_host) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (mem_ready || cnt_last) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == S_ISSUE);
    core_done = (state_q == S_RESP) && !owner_q;
    host_ack  = (state_q == S_RESP) && owner_q;
    busy      = (state_q != S_IDLE);
  end

  always_comb begin
    core_pend_d = core_pend_q;
    core_rnw_d  = core_rnw_q;
    core_adr_d  = core_adr_q;
    core_din_d  = core_din_q;
    guard_d     = guard_q;
    owner_d     = owner_q;
    mem_rnw_d   = mem_rnw_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_be_d    = mem_be_q;
    core_dout_d = core_dout_q;
    host_dout_d = host_dout_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    overrun_d   = overrun_q;
    case (state_q)
      S_IDLE: begin
        guard_d = 1'b0;
        if (grant_core) begin
          owner_d    = 1'b0;
          mem_rnw_d  = core_rnw_q;
          mem_addr_d = core_adr_q;
          mem_din_d  = core_din_q;
          mem_be_d   = 8'hFF;
        end else if (grant_host) begin
          owner_d    = 1'b1;
          mem_rnw_d  = host_rnw;
          mem_addr_d = host_adr;
          mem_din_d  = host_din;
          mem_be_d   = host_be;
        end
      end
      S_ISSUE: cnt_d = '0;
      S_WAIT: begin
        if (mem_ready) begin
          if (owner_q) host_dout_d = mem_dout;
          else         core_dout_d = mem_dout;
        end else if (cnt_last) begin
          if (owner_q) host_dout_d = '1;
          else         core_dout_d = '1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (owner_q) guard_d     = 1'b1;
        else         core_pend_d = 1'b0;
      end
      default: ;
    endcase
    // Capture after the RESP clear so a pulse coincident with core_done is kept.
    if (core_ena) begin
      if (core_free) begin
        core_pend_d = 1'b1;
        core_rnw_d  = core_rnw;
        core_adr_d  = core_adr;
        core_din_d  = core_din;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (reset) begin
      core_pend_q <= 1'b0;
      core_rnw_q  <= 1'b0;
      core_adr_q  <= '0;
      core_din_q  <= '0;
      guard_q     <= 1'b0;
      owner_q     <= 1'b1;
      mem_rnw_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_be_q    <= '0;
      core_dout_q <= '0;
      host_dout_q <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      core_pend_q <= core_pend_d;
      core_rnw_q  <= core_rnw_d;
      core_adr_q  <= core_adr_d;
      core_din_q  <= core_din_d;
      guard_q     <= guard_d;
      owner_q     <= owner_d;
      mem_rnw_q   <= mem_rnw_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_be_q    <= mem_be_d;
      core_dout_q <= core_dout_d;
      host_dout_q <= host_dout_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  assign core_dout   = core_dout_q;
  assign host_dout   = host_dout_q;
  assign mem_rnw     = mem_rnw_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_be      = mem_be_q;
  assign owner       = owner_q;
  assign timeout_err = timeout_q;
  assign overrun_err = overrun_q;

endmodule

// File: doc/save_mem_arbiter.md
Name: save_mem_arbiter

Overview:
- Shares one 64-bit DWORD-addressed memory channel between two requesters: the gb core savestate port (SAVE_out_*) and a host port (ESP32/menu side, for savestate upload and download).
- Sits between the gb core / host bridge and the memory channel (ddram ch1_* style).
- Latches the core's one-cycle request pulses, arbitrates round-robin, issues one memory transaction at a time, and routes the response back to the requester.
- Guards against a stuck memory with a timeout.

Parameters:
- ADDR_W, 26, DWORD address width.
- TIMEOUT_CYC, 4095, max cycles spent in WAIT before abort (must be ≥2).

Ports:
- hclk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- core_ena  in  1  one-cycle request pulse from core
- core_rnw  in  1  1=read, 0=write; valid with core_ena
- core_adr  in  ADDR_W  DWORD address; valid with core_ena
- core_din  in  64  write data from core; valid with core_ena
- core_dout  out  64  read data to core; valid with core_done
- core_done  out  1  one-cycle completion pulse
- host_req  in  1  level request; fields held stable until host_ack
- host_rnw  in  1  1=read, 0=write
- host_adr  in  ADDR_W  DWORD address
- host_din  in  64  write data
- host_be  in  8  byte enables for host writes
- host_dout  out  64  read data; valid with host_ack
- host_ack  out  1  one-cycle completion pulse
- mem_req  out  1  one-cycle request pulse to memory
- mem_rnw  out  1  transaction direction
- mem_addr  out  ADDR_W  DWORD address
- mem_din  out  64  write data
- mem_be  out  8  byte enables
- mem_ready  in  1  one-cycle completion from memory
- mem_dout  in  64  read data; valid with mem_ready
- owner  out  1  current/last grant: 0=core, 1=host
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky; set on timeout abort
- overrun_err  out  1  sticky; set on a dropped core request

Behaviour:
- Reset (synchronous, active-high):
  - State returns to IDLE; core pending flag and host guard are cleared.
  - All outputs are 0, except owner=1 so the core wins the first tie.
  - Reset mid-transaction abandons it silently: no done/ack pulse is issued.
- Core capture:
  - core_ena with no core request pending or in flight: latch rnw/adr/din into core_pend at the next edge.
  - core_ena while a core request is pending or in flight: drop the request and set overrun_err.
- States:
  - IDLE:
    - Candidates are core_pend and host_req (host is masked while the guard is set).
    - Only one candidate: grant it. Both: grant the one not equal to owner.
    - On grant: load mem_rnw/mem_addr/mem_din/mem_be and owner; go to ISSUE.
    - mem_be is 8'hFF for the core and host_be for the host.
  - ISSUE: mem_req=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT:
    - On mem_ready: capture mem_dout into the granted requester's dout register; go to RESP.
    - Otherwise increment the counter. When counter == TIMEOUT_CYC-1 with no mem_ready: set dout=64'hFFFF_FFFF_FFFF_FFFF, set timeout_err, go to RESP.
  - RESP:
    - Pulse core_done (owner=0) or host_ack (owner=1) for one cycle.
    - Core owner: clear core_pend. Host owner: set the host guard.
    - Go to IDLE.
  - The host guard masks host_req for the single IDLE cycle after host_ack, then self-clears. This lets the host deassert without a double grant.
- Timing:
  - Core latency: core_ena at cycle 0 gives mem_req at cycle 2. mem_ready at cycle k gives core_done at k+1; busy falls at k+2.
  - Host latency: host_req first sampled high in IDLE at cycle 0 gives mem_req at cycle 1.
- Data outputs: mem_* and *_dout hold their value between transactions; done/ack/mem_req are never high longer than one cycle.
- Ignored/accepted inputs:
  - mem_ready outside WAIT is ignored.
  - A mem_ready arriving in the same cycle the timeout fires wins: it is a normal completion with no error.
  - core_ena arriving in the same cycle as its own core_done is accepted, since the request is no longer in flight.
- Error flags: timeout_err and overrun_err clear only on reset.

Test Plan:
- Core read: core_ena, rnw=1, adr=0x000010 at cycle 0.
  - Required: mem_req at cycle 2 with mem_addr=0x10, mem_be=FF.
  - Memory answers mem_ready at cycle 5 with dout=0x0123456789ABCDEF → core_done at cycle 6 with core_dout=0x0123456789ABCDEF.
- Host write: host_req, rnw=0, adr=0x20, be=0x0F, din=0xAA.
  - Required: mem_req with mem_rnw=0, mem_be=0x0F, mem_din=0xAA.
  - mem_ready → host_ack one cycle later; host_req held one extra cycle is not re-granted.
- Contention: core_pend and host_req present in the same IDLE cycle after reset → core served first, then host.
  - Repeat with both pending → grants alternate core, host, core.
- Overrun: second core_ena while the first is in WAIT → overrun_err=1; only one mem_req issued and one core_done.
- Timeout: TIMEOUT_CYC=8, mem_ready never asserted → core_done 8 cycles after WAIT entry with core_dout=all-ones and timeout_err=1.
  - A following request completes normally.
- Reset in WAIT: reset asserted while in WAIT → outputs 0, owner=1, no done pulse.
  - A late mem_ready after reset is ignored and busy stays 0.
